// File: rtl/code_decoder_pulser_pkg.sv
// Shared widths and FSM state encoding for the code_decoder_pulser slice.
package code_decoder_pulser_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP
  } state_e;

endpackage

// File: rtl/code_decoder_pulser_if.sv
// Valid/ready code handshake between an upstream producer and the pulser.
interface code_decoder_pulser_if;
  import code_decoder_pulser_pkg::*;

  logic [CODE_W-1:0] code_in;
  logic              code_valid;
  logic              code_ready;

  modport master (
    output code_in,
    output code_valid,
    input  code_ready
  );

  modport slave (
    input  code_in,
    input  code_valid,
    output code_ready
  );

endinterface

// File: rtl/code_decoder_pulser_decode_3to8.sv
// Combinational 3-to-8 one-hot decoder with enable; output bit index equals the code.
module decode_3to8
  import code_decoder_pulser_pkg::*;
(
  input  logic [CODE_W-1:0]   code,
  input  logic                en,
  output logic [0:ONEHOT_W-1] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[code] = 1'b1;
    end
  end

endmodule

// File: rtl/code_decoder_pulser.sv
// Sequential 3-to-8 decoder: accepts a code over valid/ready, drives its one-hot
// line for HOLD_CYCLES cycles, then idles GAP_CYCLES cycles before accepting again.
module code_decoder_pulser
  import code_decoder_pulser_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  code_decoder_pulser_if.slave      code_if,
  input  logic                      clear,
  output logic [0:ONEHOT_W-1]       eight_output,
  output logic                      V
);

  generate
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255 || GAP_CYCLES > 255) begin : g_param_check
      $error("code_decoder_pulser: HOLD_CYCLES must be 1..255 and GAP_CYCLES 0..255");
    end
  endgenerate

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic [0:ONEHOT_W-1]  eight_output_q, eight_output_d;
  logic                 v_q, v_d;
  logic                 accept;
  logic                 drive_d;

  // Ready only in IDLE and never alongside clear, so clear always wins over an accept.
  assign code_if.code_ready = (state_q == IDLE) && !clear;
  assign accept             = code_if.code_valid && code_if.code_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            code_d  = code_if.code_in;
            cnt_d   = HOLD_LOAD;
            state_d = DRIVE;
          end
        end
        DRIVE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = GAP_LOAD;
            state_d = GAP;
          end
        end
        GAP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Decode from next-state values so the registered one-hot lines up with the state register.
  assign drive_d = (state_d == DRIVE);
  assign v_d     = drive_d;

  decode_3to8 u_decode (
    .code   (code_d),
    .en     (drive_d),
    .onehot (eight_output_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      code_q         <= '0;
      eight_output_q <= '0;
      v_q            <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      code_q         <= code_d;
      eight_output_q <= eight_output_d;
      v_q            <= v_d;
    end
  end

  assign eight_output = eight_output_q;
  assign V            = v_q;

endmodule

// File: tb/tb_code_decoder_pulser.sv
// Scoreboard bench: dut_a runs HOLD=4/GAP=0, dut_b runs HOLD=1/GAP=2 with encoder round-trip.
module tb_code_decoder_pulser;
  import code_decoder_pulser_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                clear_a, clear_b;
  logic [0:ONEHOT_W-1] out_a, out_b;
  logic                v_a, v_b;
  int                  cyc = 0;
  int                  checks = 0;
  int                  passed = 0;
  logic [CODE_W-1:0]   exp_q[$];

  code_decoder_pulser_if if_a ();
  code_decoder_pulser_if if_b ();

  code_decoder_pulser #(.HOLD_CYCLES(4), .GAP_CYCLES(0)) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .code_if      (if_a.slave),
    .clear        (clear_a),
    .eight_output (out_a),
    .V            (v_a)
  );

  code_decoder_pulser #(.HOLD_CYCLES(1), .GAP_CYCLES(2)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .code_if      (if_b.slave),
    .clear        (clear_b),
    .eight_output (out_b),
    .V            (v_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Index 0 is the MSB of a [0:7] vector, so shifting a leading one right by c sets bit c.
  function automatic logic [0:ONEHOT_W-1] onehot_of(input logic [CODE_W-1:0] c);
    logic [0:ONEHOT_W-1] lead = 8'b1000_0000;
    return lead >> c;
  endfunction

  function automatic logic [CODE_W-1:0] encode(input logic [0:ONEHOT_W-1] x);
    logic [CODE_W-1:0] r = '0;
    for (int i = 0; i < ONEHOT_W; i++) if (x[i]) r = CODE_W'(i);
    return r;
  endfunction

  task automatic test_reset();
    int bad = 0;
    rst_n = 1'b0;
    clear_a = 1'b0; clear_b = 1'b0;
    if_a.code_valid = 1'b0; if_b.code_valid = 1'b0;
    if_a.code_in = '0; if_b.code_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_a !== 8'b0 || v_a !== 1'b0) $display("FAIL reset_out: got out=%b V=%b want 0/0", out_a, v_a);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (if_a.code_ready !== 1'b1 || if_b.code_ready !== 1'b1)
      $display("FAIL reset_ready: got a=%b b=%b want 1/1", if_a.code_ready, if_b.code_ready);
    else passed++;
    repeat (10) begin
      @(negedge clk);
      if (out_a !== 8'b0 || v_a !== 1'b0 || if_a.code_ready !== 1'b1 ||
          out_b !== 8'b0 || v_b !== 1'b0 || if_b.code_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL idle_quiet: got %0d active cycles want 0", bad);
    else passed++;
  endtask

  task automatic test_basic_decode();
    logic [CODE_W-1:0] exp;
    if_a.code_in = 3'd5;
    if_a.code_valid = 1'b1;
    exp_q.push_back(3'd5);
    checks++;
    if (if_a.code_ready !== 1'b1) $display("FAIL basic_ready_pre: got %b want 1", if_a.code_ready);
    else passed++;
    @(negedge clk);
    if_a.code_valid = 1'b0;
    exp = exp_q.pop_front();
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (out_a !== onehot_of(exp) || v_a !== 1'b1 || if_a.code_ready !== 1'b0)
        $display("FAIL basic_drive_%0d: got out=%b V=%b rdy=%b want out=%b V=1 rdy=0",
                 k, out_a, v_a, if_a.code_ready, onehot_of(exp));
      else passed++;
      @(negedge clk);
    end
    checks++;
    if (out_a !== 8'b0 || v_a !== 1'b0 || if_a.code_ready !== 1'b1)
      $display("FAIL basic_end: got out=%b V=%b rdy=%b want 0/0/1", out_a, v_a, if_a.code_ready);
    else passed++;
  endtask

  task automatic test_sweep_roundtrip();
    logic [CODE_W-1:0] exp;
    int w, acc, last_acc;
    last_acc = 0;
    if_b.code_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if_b.code_in = CODE_W'(c);
      exp_q.push_back(CODE_W'(c));
      w = 0;
      while (!if_b.code_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      checks++;
      if (w >= 20) $display("FAIL sweep_wait_ready_%0d: got timeout want ready within 20", c);
      else passed++;
      @(negedge clk);
      acc = cyc;
      if (c > 0) begin
        checks++;
        if (acc - last_acc !== 4) $display("FAIL sweep_spacing_%0d: got %0d want 4", c, acc - last_acc);
        else passed++;
      end
      last_acc = acc;
      exp = exp_q.pop_front();
      checks++;
      if (v_b !== 1'b1 || encode(out_b) !== exp || out_b !== onehot_of(exp))
        $display("FAIL sweep_roundtrip_%0d: got enc=%0d out=%b V=%b want enc=%0d V=1",
                 c, encode(out_b), out_b, v_b, exp);
      else passed++;
      @(negedge clk);
      checks++;
      if (v_b !== 1'b0 || out_b !== 8'b0)
        $display("FAIL sweep_gap_%0d: got out=%b V=%b want 0/0", c, out_b, v_b);
      else passed++;
    end
    if_b.code_valid = 1'b0;
    w = 0;
    while (!if_b.code_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic test_backpressure();
    logic [CODE_W-1:0] exp;
    int bad = 0;
    if_a.code_in = 3'd6;
    if_a.code_valid = 1'b1;
    exp_q.push_back(3'd6);
    @(negedge clk);
    if_a.code_in = 3'd3;
    exp_q.push_back(3'd3);
    exp = exp_q.pop_front();
    for (int k = 0; k < 4; k++) begin
      if (out_a !== onehot_of(exp) || v_a !== 1'b1 || if_a.code_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) $display("FAIL bp_window: got %0d wrong cycles want 0 (code 6 held 4 cycles)", bad);
    else passed++;
    checks++;
    if (if_a.code_ready !== 1'b1 || out_a !== 8'b0)
      $display("FAIL bp_idle: got rdy=%b out=%b want 1/0", if_a.code_ready, out_a);
    else passed++;
    @(negedge clk);
    if_a.code_valid = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (out_a !== onehot_of(exp) || v_a !== 1'b1)
      $display("FAIL bp_second: got out=%b V=%b want out=%b V=1", out_a, v_a, onehot_of(exp));
    else passed++;
    repeat (4) @(negedge clk);
    checks++;
    if (if_a.code_ready !== 1'b1 || out_a !== 8'b0 || v_a !== 1'b0)
      $display("FAIL bp_done: got rdy=%b out=%b V=%b want 1/0/0", if_a.code_ready, out_a, v_a);
    else passed++;
  endtask

  task automatic test_clear();
    logic [CODE_W-1:0] exp;
    if_a.code_in = 3'd2;
    if_a.code_valid = 1'b1;
    exp_q.push_back(3'd2);
    @(negedge clk);
    if_a.code_valid = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (out_a !== onehot_of(exp) || v_a !== 1'b1)
      $display("FAIL clear_first_drive: got out=%b V=%b want out=%b V=1", out_a, v_a, onehot_of(exp));
    else passed++;
    @(negedge clk);
    clear_a = 1'b1;
    @(negedge clk);
    clear_a = 1'b0;
    #1;
    checks++;
    if (out_a !== 8'b0 || v_a !== 1'b0 || if_a.code_ready !== 1'b1)
      $display("FAIL clear_abort: got out=%b V=%b rdy=%b want 0/0/1", out_a, v_a, if_a.code_ready);
    else passed++;
    @(negedge clk);
    clear_a = 1'b1;
    if_a.code_in = 3'd7;
    if_a.code_valid = 1'b1;
    #1;
    checks++;
    if (if_a.code_ready !== 1'b0) $display("FAIL clear_ready_low: got %b want 0", if_a.code_ready);
    else passed++;
    @(negedge clk);
    clear_a = 1'b0;
    if_a.code_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_a !== 8'b0 || v_a !== 1'b0)
      $display("FAIL clear_no_accept: got out=%b V=%b want 0/0", out_a, v_a);
    else passed++;
  endtask

  task automatic test_async_reset();
    int bad = 0;
    if_a.code_in = 3'd1; if_a.code_valid = 1'b1;
    if_b.code_in = 3'd4; if_b.code_valid = 1'b1;
    @(negedge clk);
    if_a.code_valid = 1'b0;
    if_b.code_valid = 1'b0;
    checks++;
    if (out_a !== onehot_of(3'd1) || out_b !== onehot_of(3'd4))
      $display("FAIL ar_pre_drive: got a=%b b=%b want %b %b", out_a, out_b, onehot_of(3'd1), onehot_of(3'd4));
    else passed++;
    @(negedge clk);
    checks++;
    if (v_b !== 1'b0 || out_b !== 8'b0 || if_b.code_ready !== 1'b0 || v_a !== 1'b1)
      $display("FAIL ar_mid_state: got b V=%b rdy=%b a V=%b want 0/0/1", v_b, if_b.code_ready, v_a);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_a !== 8'b0 || v_a !== 1'b0)
      $display("FAIL ar_async_drop: got out=%b V=%b want 0/0 before edge", out_a, v_a);
    else passed++;
    checks++;
    if (if_b.code_ready !== 1'b1)
      $display("FAIL ar_gap_cleared: got rdy=%b want 1 before edge", if_b.code_ready);
    else passed++;
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_a !== 8'b0 || v_a !== 1'b0 || if_a.code_ready !== 1'b1 ||
          out_b !== 8'b0 || v_b !== 1'b0 || if_b.code_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL ar_no_stale: got %0d active cycles want 0", bad);
    else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting code_decoder_pulser bench");
    test_reset();
    test_basic_decode();
    test_sweep_roundtrip();
    test_backpressure();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
